// File: rtl/bp_be_issue_queue_if.sv
// Bundle of the front-end enqueue port, the decoder issue port and the
// clear/roll/commit controls of the BE issue queue.
interface bp_be_issue_queue_if #(
    parameter int instr_width_p = 32,
    parameter int vaddr_width_p = 39,
    parameter int exc_width_p   = 3
);
    // Both handshakes transfer on a cycle where valid and ready are high together;
    // valid never waits on ready, and ready/valid outputs come from registers only.
    logic                     clr_v_i;
    logic                     roll_v_i;
    logic                     commit_v_i;

    logic                     fe_v_i;
    logic                     fe_ready_o;
    logic                     fe_exc_not_instr_i;
    logic [exc_width_p-1:0]   fe_exc_i;
    logic [vaddr_width_p-1:0] fe_pc_i;
    logic [instr_width_p-1:0] fe_instr_i;

    logic                     issue_v_o;
    logic                     issue_ready_i;
    logic                     issue_exc_not_instr_o;
    logic [exc_width_p-1:0]   issue_exc_o;
    logic [vaddr_width_p-1:0] issue_pc_o;
    logic [instr_width_p-1:0] issue_instr_o;

    logic                     empty_o;
    logic                     full_o;

    modport master (
        output clr_v_i, roll_v_i, commit_v_i,
        output fe_v_i, fe_exc_not_instr_i, fe_exc_i, fe_pc_i, fe_instr_i,
        input  fe_ready_o,
        input  issue_v_o, issue_exc_not_instr_o, issue_exc_o, issue_pc_o, issue_instr_o,
        output issue_ready_i,
        input  empty_o, full_o
    );

    modport slave (
        input  clr_v_i, roll_v_i, commit_v_i,
        input  fe_v_i, fe_exc_not_instr_i, fe_exc_i, fe_pc_i, fe_instr_i,
        output fe_ready_o,
        output issue_v_o, issue_exc_not_instr_o, issue_exc_o, issue_pc_o, issue_instr_o,
        input  issue_ready_i,
        output empty_o, full_o
    );
endinterface

// File: rtl/bp_be_issue_queue.sv
// Checkpointed circular buffer between the FE queue and the BE decoder:
// write/issue/commit pointers allow replay from the oldest uncommitted entry.
module bp_be_issue_queue #(
    parameter int els_p         = 8,
    parameter int instr_width_p = 32,
    parameter int vaddr_width_p = 39,
    parameter int exc_width_p   = 3
) (
    input logic              clk_i,
    input logic              reset_n_i,
    bp_be_issue_queue_if.slave q
);
    localparam int idx_w   = $clog2(els_p);
    localparam int ptr_w   = idx_w + 1;
    localparam int entry_w = 1 + exc_width_p + vaddr_width_p + instr_width_p;

    typedef logic [ptr_w-1:0] ptr_t;

    ptr_t wptr, rptr, cptr;
    ptr_t wptr_next, rptr_next, cptr_next;
    ptr_t occupancy;

    logic [entry_w-1:0] mem [els_p];
    logic [entry_w-1:0] rd_entry;

    logic full, empty, issue_v;
    logic enq_fire, issue_fire, commit_fire;

    // Status depends on registered pointers only; the wrap bit separates full from empty.
    assign occupancy = wptr - cptr;
    assign full      = (occupancy == ptr_t'(els_p));
    assign empty     = (wptr == cptr);
    assign issue_v   = (rptr != wptr);

    assign q.full_o     = full;
    assign q.empty_o    = empty;
    assign q.fe_ready_o = ~full;
    assign q.issue_v_o  = issue_v;

    assign enq_fire    = q.fe_v_i & ~full & ~q.clr_v_i;
    assign issue_fire  = issue_v & q.issue_ready_i & ~q.roll_v_i & ~q.clr_v_i;
    // An illegal commit with nothing issued leaves cptr where it is.
    assign commit_fire = q.commit_v_i & ~q.clr_v_i & (cptr != rptr);

    always_comb begin
        wptr_next = wptr;
        rptr_next = rptr;
        cptr_next = cptr;
        if (q.clr_v_i) begin
            wptr_next = '0;
            rptr_next = '0;
            cptr_next = '0;
        end else begin
            if (enq_fire)    wptr_next = wptr + ptr_t'(1);
            if (commit_fire) cptr_next = cptr + ptr_t'(1);
            if (q.roll_v_i)      rptr_next = cptr_next;
            else if (issue_fire) rptr_next = rptr + ptr_t'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr <= '0;
            rptr <= '0;
            cptr <= '0;
        end else begin
            wptr <= wptr_next;
            rptr <= rptr_next;
            cptr <= cptr_next;
        end
    end

    // Storage is deliberately left unreset; issue_v gates its meaning.
    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            mem[wptr[idx_w-1:0]] <= {q.fe_exc_not_instr_i, q.fe_exc_i, q.fe_pc_i, q.fe_instr_i};
        end
    end

    assign rd_entry = mem[rptr[idx_w-1:0]];
    assign {q.issue_exc_not_instr_o, q.issue_exc_o, q.issue_pc_o, q.issue_instr_o} = rd_entry;

    commit_legal_a: assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        (q.commit_v_i && !q.clr_v_i) |-> (cptr != rptr)
    );
endmodule

// File: tb/tb_bp_be_issue_queue.sv
// Directed and randomized bench for bp_be_issue_queue against a queue-based
// reference model (held entries in order plus a count of issued ones).
module tb_bp_be_issue_queue;
    localparam int els_lp  = 8;
    localparam int instr_w = 32;
    localparam int vaddr_w = 39;
    localparam int exc_w   = 3;
    localparam int entry_w = 1 + exc_w + vaddr_w + instr_w;

    typedef logic [entry_w-1:0] entry_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    entry_t exp_q[$];
    int     iss_cnt  = 0;
    int     n_assert = 0;
    int     n_fail   = 0;

    bp_be_issue_queue_if #(
        .instr_width_p(instr_w), .vaddr_width_p(vaddr_w), .exc_width_p(exc_w)
    ) q_if ();

    bp_be_issue_queue #(
        .els_p(els_lp), .instr_width_p(instr_w), .vaddr_width_p(vaddr_w), .exc_width_p(exc_w)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .q        (q_if)
    );

    always #5 clk = ~clk;

    function automatic entry_t mk(input logic eni, input logic [exc_w-1:0] exc,
                                  input logic [vaddr_w-1:0] pc, input logic [instr_w-1:0] instr);
        return {eni, exc, pc, instr};
    endfunction

    function automatic entry_t issue_entry();
        return {q_if.issue_exc_not_instr_o, q_if.issue_exc_o, q_if.issue_pc_o, q_if.issue_instr_o};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        int sz;
        sz = exp_q.size();
        check({tag, ".full"},     128'(q_if.full_o),     128'(sz == els_lp));
        check({tag, ".empty"},    128'(q_if.empty_o),    128'(sz == 0));
        check({tag, ".fe_ready"}, 128'(q_if.fe_ready_o), 128'(sz != els_lp));
        check({tag, ".issue_v"},  128'(q_if.issue_v_o),  128'(iss_cnt < sz));
        if (iss_cnt < sz) check({tag, ".entry"}, 128'(issue_entry()), 128'(exp_q[iss_cnt]));
    endtask

    task automatic drive_idle();
        q_if.clr_v_i = 1'b0; q_if.roll_v_i = 1'b0; q_if.commit_v_i = 1'b0;
        q_if.fe_v_i = 1'b0; q_if.fe_exc_not_instr_i = 1'b0; q_if.fe_exc_i = '0;
        q_if.fe_pc_i = '0; q_if.fe_instr_i = '0; q_if.issue_ready_i = 1'b0;
    endtask

    // One clock of stimulus; the model advances from the pre-edge state.
    task automatic cycle(input string tag, input logic fe_v, input entry_t e, input logic rdy,
                         input logic com, input logic roll, input logic clr);
        int sz;
        bit enq_f, iss_f, com_f;
        q_if.fe_v_i = fe_v;
        {q_if.fe_exc_not_instr_i, q_if.fe_exc_i, q_if.fe_pc_i, q_if.fe_instr_i} = e;
        q_if.issue_ready_i = rdy;
        q_if.commit_v_i = com;
        q_if.roll_v_i = roll;
        q_if.clr_v_i = clr;
        sz    = exp_q.size();
        enq_f = fe_v && (sz < els_lp) && !clr;
        iss_f = (iss_cnt < sz) && rdy && !roll && !clr;
        com_f = com && (iss_cnt > 0) && !clr;
        @(posedge clk);
        #1;
        if (clr) begin
            exp_q.delete();
            iss_cnt = 0;
        end else begin
            if (com_f) begin
                void'(exp_q.pop_front());
                iss_cnt--;
            end
            if (iss_f) iss_cnt++;
            if (enq_f) exp_q.push_back(e);
            if (roll) iss_cnt = 0;
        end
        drive_idle();
        check_outputs(tag);
    endtask

    task automatic idle_cycle(input string tag);
        cycle(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int     sent, n_out, budget;
        logic   eni;
        entry_t e;

        // Reset state, checked while reset is still held.
        drive_idle();
        #12;
        check_outputs("reset_held");
        @(negedge clk);
        reset_n = 1'b1;
        idle_cycle("reset_rel");

        // Fill with the decoder stalled; the ninth offer must be ignored.
        for (int i = 0; i < els_lp; i++)
            cycle("fill", 1'b1, mk(1'b0, '0, 39'h100 + 39'(4 * i), $urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        check("fill.full", 128'(q_if.full_o), 128'(1));
        check("fill.ready", 128'(q_if.fe_ready_o), 128'(0));
        cycle("fill9", 1'b1, mk(1'b0, '0, 39'h120, $urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        check("fill.pc", 128'(q_if.issue_pc_o), 128'(39'h100));

        // Issue three, commit two.
        cycle("ic1", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("ic1.full", 128'(q_if.full_o), 128'(1));
        cycle("ic2", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("ic2.full", 128'(q_if.full_o), 128'(0));
        check("ic2.ready", 128'(q_if.fe_ready_o), 128'(1));
        cycle("ic3", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("ic3.pc", 128'(q_if.issue_pc_o), 128'(39'h10C));

        // Leave five held, then clear with a simultaneous enqueue.
        cycle("clr_prep", 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("clr", 1'b1, mk(1'b0, '0, 39'h200, $urandom), 1'b0, 1'b0, 1'b0, 1'b1);
        check("clr.empty", 128'(q_if.empty_o), 128'(1));
        check("clr.issue_v", 128'(q_if.issue_v_o), 128'(0));
        idle_cycle("clr_after");

        // Roll: issue 0x100..0x108 with 0x100 committed, roll against a live handshake.
        for (int i = 0; i < 4; i++)
            cycle("roll_fill", 1'b1, mk(1'b0, '0, 39'h100 + 39'(4 * i), $urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("roll_i0", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("roll_i1", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle("roll_i2", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("roll", 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("roll.pc", 128'(q_if.issue_pc_o), 128'(39'h104));
        idle_cycle("roll_after");

        // Stream 20 entries through with continuous issue and commit.
        cycle("wrap_clr", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        sent = 0; n_out = 0; budget = 0;
        while ((sent < 20 || n_out < 20 || iss_cnt > 0) && budget < 100) begin
            budget++;
            eni = (sent == 13);
            e = mk(eni, eni ? 3'd3 : 3'd0, 39'h1000 + 39'(4 * sent), $urandom);
            if (q_if.issue_v_o) begin
                check("wrap.pc", 128'(q_if.issue_pc_o), 128'(39'h1000 + 39'(4 * n_out)));
                check("wrap.eni", 128'(q_if.issue_exc_not_instr_o), 128'(n_out == 13));
                check("wrap.exc", 128'(q_if.issue_exc_o), 128'((n_out == 13) ? 3 : 0));
                n_out++;
            end
            if (sent < 20 && exp_q.size() < els_lp) begin
                cycle("wrap", 1'b1, e, 1'b1, iss_cnt > 0, 1'b0, 1'b0);
                sent++;
            end else begin
                cycle("wrap", 1'b0, '0, 1'b1, iss_cnt > 0, 1'b0, 1'b0);
            end
        end
        check("wrap.count", 128'(n_out), 128'(20));
        check("wrap.empty", 128'(q_if.empty_o), 128'(1));

        // Asynchronous reset between clock edges.
        for (int i = 0; i < 3; i++)
            cycle("ar_fill", 1'b1, mk(1'b0, '0, 39'h300 + 39'(4 * i), $urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async.issue_v", 128'(q_if.issue_v_o), 128'(0));
        check("async.empty", 128'(q_if.empty_o), 128'(1));
        exp_q.delete();
        iss_cnt = 0;
        @(negedge clk);
        reset_n = 1'b1;
        idle_cycle("async_after");

        // Randomized traffic, commits only when something is issued.
        for (int i = 0; i < 400; i++) begin
            e = mk(1'($urandom_range(0, 1)), 3'($urandom), 39'($urandom), $urandom);
            cycle("rand", 1'($urandom_range(0, 1)), e, 1'($urandom_range(0, 1)),
                  (iss_cnt > 0) && ($urandom_range(0, 1) == 1),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/bp_be_issue_queue.md
Name: bp_be_issue_queue

Overview:
- Checkpointed circular buffer between the FE queue interface and the BE instruction decoder.
- Accepts fetched entries from the front end. Each entry is either an instruction or an FE exception with its code.
- Presents entries in order to the decoder.
- Keeps every issued-but-uncommitted entry, so a rollback can replay from the oldest uncommitted entry and a clear can flush the whole buffer.

Parameters:
- els_p, default 8: number of entries. Must be a power of 2 and at least 2.
- instr_width_p, default 32: instruction width; matches the decoder input.
- vaddr_width_p, default 39: PC width.
- exc_width_p, default 3: width of the FE exception code.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous, active-low reset
- clr_v_i  in  1  flush all entries
- roll_v_i  in  1  rewind the issue pointer to the commit pointer
- commit_v_i  in  1  retire the oldest issued entry
- fe_v_i  in  1  enqueue valid
- fe_ready_o  out  1  enqueue ready
- fe_exc_not_instr_i  in  1  entry is an exception, not an instruction
- fe_exc_i  in  exc_width_p  exception code
- fe_pc_i  in  vaddr_width_p  entry PC
- fe_instr_i  in  instr_width_p  instruction
- issue_v_o  out  1  issue entry valid
- issue_ready_i  in  1  decoder accepts the entry
- issue_exc_not_instr_o  out  1  entry is an exception
- issue_exc_o  out  exc_width_p  exception code
- issue_pc_o  out  vaddr_width_p  entry PC
- issue_instr_o  out  instr_width_p  instruction
- empty_o  out  1  no committed-pending entries
- full_o  out  1  els_p entries held

Behaviour:
- Reset:
  - Single clock clk_i; asynchronous active-low reset reset_n_i.
  - Reset asserted zeroes wptr, rptr and cptr immediately.
  - Outputs during and after reset: issue_v_o=0, fe_ready_o=1, empty_o=1, full_o=0.
  - Storage array is not reset. Data outputs are don't-care while issue_v_o=0.
- Pointers:
  - Three pointers, each log2(els_p)+1 bits; the MSB is the wrap bit. Index = low bits.
  - wptr: next slot to write. rptr: next entry to issue. cptr: oldest uncommitted entry.
  - Invariant: cptr <= rptr <= wptr, under modular distance.
- Derived status:
  - occupancy = wptr - cptr.
  - full_o = (occupancy == els_p); empty_o = (wptr == cptr).
  - fe_ready_o = ~full_o.
  - issue_v_o = (rptr != wptr).
  - All four are functions of registered pointers only; none depends combinationally on any input.
- Enqueue:
  - Fires when fe_v_i & fe_ready_o & ~clr_v_i.
  - Writes {exc_not_instr, exc, pc, instr} at wptr; wptr increments.
  - A write into an empty issue window is visible on issue outputs the next cycle (latency 1, no bypass).
  - fe_v_i while full: ignored, nothing written. A commit in the same cycle does not open the slot until the next cycle.
- Issue:
  - issue_* data is read combinationally from the array at rptr.
  - Fires when issue_v_o & issue_ready_i & ~roll_v_i & ~clr_v_i; rptr increments.
- Commit:
  - Fires when commit_v_i & ~clr_v_i; cptr increments.
  - commit_v_i when cptr == rptr is illegal. An assertion flags it; the RTL holds cptr unchanged.
- Roll:
  - When roll_v_i & ~clr_v_i: rptr <= cptr_next. cptr_next includes a same-cycle commit.
  - A same-cycle issue handshake is discarded.
  - A same-cycle enqueue still completes.
- Clear:
  - When clr_v_i: wptr, rptr and cptr all reset to 0 next cycle.
  - Same-cycle enqueue, issue and commit are all dropped.
- Priority: reset > clr > roll > {enqueue, issue, commit}, the last three being concurrent.
- Wrap-around: pointers wrap naturally at 2*els_p. Full and empty are distinguished by the wrap bit.
- Entries pass through unmodified. Exception entries are treated exactly like instructions; decode interprets them downstream.

Test Plan:
- Fill: reset, then enqueue 8 entries (pc=0x100..0x11C) with issue_ready_i=0 -> full_o=1, fe_ready_o=0. A 9th fe_v_i is ignored. issue_pc_o=0x100.
- Issue and commit: from full, issue 3 and commit 2 -> after 3 handshakes issue_pc_o=0x10C. After the commits, occupancy=6, full_o=0, fe_ready_o=1 the cycle after the first commit.
- Roll: after issuing 0x100..0x108 with 0x100 committed, assert roll_v_i together with issue_ready_i -> next cycle issue_pc_o=0x104; the discarded handshake does not advance rptr.
- Clear: with 5 entries held, assert clr_v_i with fe_v_i=1 -> next cycle empty_o=1, issue_v_o=0; the simultaneous entry is not stored.
- Wrap and exceptions: stream 20 entries with continuous issue and commit, where entry 13 has exc_not_instr=1, exc=3 -> in-order pc sequence, entry 13 emerges with its exception fields intact, no drops, pointers wrap twice.
- Async reset: assert reset_n_i low mid-stream between clock edges -> issue_v_o=0 and empty_o=1 immediately, before the next clk_i edge.
